// File: rtl/std_out_pkg.sv
// Shared serializer state encoding and 8N1 frame constants for the stdout UART.
package std_out_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/std_out_uart_tx_if.sv
// Stdout word handshake: upstream raises ready with a word, the UART pulses ack on capture.
interface std_out_uart_tx_if;
    import std_out_pkg::*;

    logic              stdOutReadyInput;
    logic [WORD_W-1:0] stdOutDataInput;
    logic              stdOutAckOutput;

    modport master (output stdOutReadyInput, output stdOutDataInput, input stdOutAckOutput);
    modport slave  (input stdOutReadyInput, input stdOutDataInput, output stdOutAckOutput);
endinterface

// File: rtl/std_out_fifo.sv
// Power-of-two FIFO with extra-MSB pointers; push while full is legal only alongside a pop.
module std_out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/std_out_uart_tx.sv
// Stdout word capture into a FIFO and 8N1 UART serializer.
// Define STD_OUT_UART_TX_FULL_WORD_EN to send all four bytes of each word, [7:0] first.
module std_out_uart_tx
    import std_out_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic              clockInput,
    input  logic              resetInput,
    std_out_uart_tx_if.slave  stdOut,
    output logic              txOutput,
    output logic              busyOutput
);
    localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
`ifdef STD_OUT_UART_TX_FULL_WORD_EN
    localparam int unsigned FIFO_W = WORD_W;
`else
    localparam int unsigned FIFO_W = DATA_BITS;
`endif

    tx_state_e        state, state_d;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [FIFO_W-1:0] head, frame_word;
    logic [PTR_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             push, pop, ack, bit_done, more_bytes;
    logic [7:0]       cur_byte;
    logic             tx_d, busy_d;

    // Ready is ignored during the ack cycle; a full FIFO still accepts when popping.
    assign push     = stdOut.stdOutReadyInput && !ack && (!fifo_full || pop);
    assign bit_done = (baud_cnt == CNT_W'(CLOCKS_PER_BIT - 1));
    assign stdOut.stdOutAckOutput = ack;

    std_out_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clockInput),
        .rst   (resetInput),
        .push  (push),
        .pop   (pop),
        .wdata (stdOut.stdOutDataInput[FIFO_W-1:0]),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef STD_OUT_UART_TX_FULL_WORD_EN
    logic [1:0] byte_idx;

    assign more_bytes = (byte_idx != 2'd3);
    assign cur_byte   = frame_word[{byte_idx, 3'b000} +: 8];

    always_ff @(posedge clockInput) begin
        if (resetInput)                                    byte_idx <= '0;
        else if (pop)                                      byte_idx <= '0;
        else if (state == ST_STOP && bit_done && more_bytes) byte_idx <= byte_idx + 2'd1;
    end
`else
    logic [WORD_W-DATA_BITS-1:0] unused_data;

    assign unused_data = stdOut.stdOutDataInput[WORD_W-1:DATA_BITS];
    assign more_bytes  = 1'b0;
    assign cur_byte    = frame_word;
`endif

    always_ff @(posedge clockInput) begin
        if (resetInput) state <= ST_IDLE;
        else            state <= state_d;
    end

    always_comb begin
        state_d    = state;
        pop        = 1'b0;
        bit_cnt_d  = bit_cnt;
        baud_cnt_d = '0;
        if (state != ST_IDLE) baud_cnt_d = bit_done ? '0 : baud_cnt + CNT_W'(1);
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_START;
                    pop     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (more_bytes) begin
                        state_d = ST_START;
                    end else if (!fifo_empty) begin
                        state_d = ST_START;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level and busy are derived from the next state so the registered pins align with it.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = cur_byte[bit_cnt_d];
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE) || push || (fifo_count > PTR_W'(pop));
    end

    always_ff @(posedge clockInput) begin
        if (resetInput) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            frame_word <= '0;
        end else begin
            baud_cnt <= baud_cnt_d;
            bit_cnt  <= bit_cnt_d;
            if (pop) frame_word <= head;
        end
    end

    always_ff @(posedge clockInput) begin
        if (resetInput) begin
            txOutput   <= 1'b1;
            busyOutput <= 1'b0;
            ack        <= 1'b0;
        end else begin
            txOutput   <= tx_d;
            busyOutput <= busy_d;
            ack        <= push;
        end
    end
endmodule
